// File: rtl/packetizer.sv
// packetizer: gathers four independently handshaked fields into one packet on a valid/ready channel.
// Build option PKT_PARITY_EN appends an even-parity bit as packet_o[PKT_W].
module packetizer #(
   parameter int FILTER_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      timestep_i,
   input  logic                      timestep_valid,
   output logic                      timestep_ready,
   input  logic                      ifmapb_filter_i,
   input  logic                      ifmapb_filter_valid,
   output logic                      ifmapb_filter_ready,
   input  logic [1:0]                filter_row_i,
   input  logic                      filter_row_valid,
   output logic                      filter_row_ready,
   input  logic [3*FILTER_WIDTH-1:0] data_i,
   input  logic                      data_valid,
   output logic                      data_ready,
`ifdef PKT_PARITY_EN
   output logic [3*FILTER_WIDTH+4:0] packet_o,
`else
   output logic [3*FILTER_WIDTH+3:0] packet_o,
`endif
   output logic                      packet_valid,
   input  logic                      packet_ready
);

   localparam int DW    = 3*FILTER_WIDTH;
   localparam int PKT_W = DW + 4;
`ifdef PKT_PARITY_EN
   localparam int OUT_W = PKT_W + 1;
`else
   localparam int OUT_W = PKT_W;
`endif

   // Member order matches the packet layout, so the struct is the packet body.
   typedef struct packed {
      logic          ts;
      logic          ibf;
      logic [1:0]    row;
      logic [DW-1:0] data;
   } fields_t;

   typedef enum logic {OUT_EMPTY = 1'b0, OUT_FULL = 1'b1} out_st_t;

   fields_t          fld_q, fld_d;
   logic [3:0]       cap_q, cap_d;
   logic [OUT_W-1:0] out_q, out_d;
   out_st_t          st_q, st_d;

   logic [3:0] fvalid, fready, fxfer;
   logic       assemble;

   assign fvalid = {data_valid, filter_row_valid, ifmapb_filter_valid, timestep_valid};

   // Output slot frees up this edge if it is empty or being drained.
   always_comb begin
      assemble = (&cap_q) && ((st_q == OUT_EMPTY) || packet_ready);
      fready   = ~cap_q | {4{assemble}};
      fxfer    = fvalid & fready;
   end

   assign timestep_ready      = fready[0];
   assign ifmapb_filter_ready = fready[1];
   assign filter_row_ready    = fready[2];
   assign data_ready          = fready[3];

   always_comb begin
      fld_d = fld_q;
      if (fxfer[0]) fld_d.ts   = timestep_i;
      if (fxfer[1]) fld_d.ibf  = ifmapb_filter_i;
      if (fxfer[2]) fld_d.row  = filter_row_i;
      if (fxfer[3]) fld_d.data = data_i;

      // A field arriving on the assemble edge starts the next packet.
      cap_d = (assemble ? 4'b0000 : cap_q) | fxfer;

      out_d = out_q;
      st_d  = st_q;
      if (assemble) begin
`ifdef PKT_PARITY_EN
         out_d = {^fld_q, fld_q};
`else
         out_d = fld_q;
`endif
         st_d  = OUT_FULL;
      end else if ((st_q == OUT_FULL) && packet_ready) begin
         st_d  = OUT_EMPTY;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fld_q <= '0;
         cap_q <= '0;
         out_q <= '0;
         st_q  <= OUT_EMPTY;
      end else begin
         fld_q <= fld_d;
         cap_q <= cap_d;
         out_q <= out_d;
         st_q  <= st_d;
      end
   end

   assign packet_o     = out_q;
   assign packet_valid = (st_q == OUT_FULL);

endmodule

// File: tb/tb_packetizer.sv
// Scoreboard bench for packetizer: per-field FIFO reference model, random and directed stimulus.
module tb_packetizer;
   localparam int DW    = 24;
   localparam int PKT_W = 28;
`ifdef PKT_PARITY_EN
   localparam int OW = PKT_W + 1;
`else
   localparam int OW = PKT_W;
`endif

   logic          clk = 1'b0, rst_n = 1'b0;
   logic          ts_i = 1'b0, ts_v = 1'b0, ibf_i = 1'b0, ibf_v = 1'b0;
   logic [1:0]    row_i = '0;
   logic          row_v = 1'b0;
   logic [DW-1:0] data_i = '0;
   logic          data_v = 1'b0;
   logic          ts_r, ibf_r, row_r, data_r;
   logic [OW-1:0] pkt;
   logic          pv;
   logic          pr = 1'b0;

   int vectors = 0, errors = 0;

   always #5 clk = ~clk;

   packetizer #(.FILTER_WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .timestep_i(ts_i), .timestep_valid(ts_v), .timestep_ready(ts_r),
      .ifmapb_filter_i(ibf_i), .ifmapb_filter_valid(ibf_v), .ifmapb_filter_ready(ibf_r),
      .filter_row_i(row_i), .filter_row_valid(row_v), .filter_row_ready(row_r),
      .data_i(data_i), .data_valid(data_v), .data_ready(data_r),
      .packet_o(pkt), .packet_valid(pv), .packet_ready(pr)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [OW-1:0] mkpkt(input logic ts, input logic ibf,
                                           input logic [1:0] row, input logic [DW-1:0] d);
      logic [PKT_W-1:0] p;
      p = {ts, ibf, row, d};
`ifdef PKT_PARITY_EN
      return {^p, p};
`else
      return p;
`endif
   endfunction

   // Reference model: each field is a FIFO of accepted values; the k-th packet
   // is the k-th value of every field, and the output holds one packet.
   logic          q_ts[$], q_ibf[$];
   logic [1:0]    q_row[$];
   logic [DW-1:0] q_data[$];
   logic [OW-1:0] exp_q[$];
   bit            m_full = 1'b0, m_asm;
   bit [3:0]      m_er, acc = '0;
   int            npkts = 0;

   always @(negedge clk) begin
      #1;
      if (!rst_n) begin
         q_ts.delete(); q_ibf.delete(); q_row.delete(); q_data.delete();
         exp_q.delete();
         m_full = 1'b0;
         acc    = '0;
      end else begin
         m_asm = (q_ts.size() > 0) && (q_ibf.size() > 0) && (q_row.size() > 0) &&
                 (q_data.size() > 0) && (!m_full || pr);
         m_er[0] = (q_ts.size()   == 0) || m_asm;
         m_er[1] = (q_ibf.size()  == 0) || m_asm;
         m_er[2] = (q_row.size()  == 0) || m_asm;
         m_er[3] = (q_data.size() == 0) || m_asm;
         chk("timestep_ready", ts_r, m_er[0]);
         chk("ifmapb_filter_ready", ibf_r, m_er[1]);
         chk("filter_row_ready", row_r, m_er[2]);
         chk("data_ready", data_r, m_er[3]);
         chk("packet_valid", pv, m_full);
         acc = {data_v, row_v, ibf_v, ts_v} & m_er;
         if (m_asm)
            exp_q.push_back(mkpkt(q_ts.pop_front(), q_ibf.pop_front(),
                                  q_row.pop_front(), q_data.pop_front()));
         if (acc[0]) q_ts.push_back(ts_i);
         if (acc[1]) q_ibf.push_back(ibf_i);
         if (acc[2]) q_row.push_back(row_i);
         if (acc[3]) q_data.push_back(data_i);
         if (m_asm) m_full = 1'b1;
         else if (m_full && pr) m_full = 1'b0;
      end
   end

   // Monitor: pops on every packet transfer, checks hold while stalled.
   bit            stall = 1'b0;
   logic [OW-1:0] hold_pkt;
   always @(negedge clk) begin
      if (!rst_n) begin
         stall = 1'b0;
      end else begin
         if (stall) begin
            chk("stall_hold_packet", pkt, hold_pkt);
            chk("stall_hold_valid", pv, 1'b1);
         end
         if (pv && pr) begin
            npkts++;
            if (exp_q.size() == 0) begin
               vectors++; errors++;
               $display("FAIL unexpected_packet: got %0h expected none", pkt);
            end else begin
               chk("packet", pkt, exp_q.pop_front());
            end
`ifdef PKT_PARITY_EN
            chk("even_parity", ^pkt, 1'b0);
`endif
         end
         stall    = pv && !pr;
         hold_pkt = pkt;
      end
   end

   // Random driver: a presented field is held until accepted.
   bit rnd_en = 1'b0;
   int p_val = 100, p_rdy = 100, n_sets = 0;
   int issued[4];

   function automatic bit roll(input int pct);
      return int'($urandom_range(99)) < pct;
   endfunction

   always @(posedge clk) begin
      if (rnd_en) begin
         #1;
         if (!ts_v || acc[0]) begin
            ts_v = 1'b0;
            if (issued[0] < n_sets && roll(p_val)) begin ts_v = 1'b1; ts_i = 1'($urandom); issued[0]++; end
         end
         if (!ibf_v || acc[1]) begin
            ibf_v = 1'b0;
            if (issued[1] < n_sets && roll(p_val)) begin ibf_v = 1'b1; ibf_i = 1'($urandom); issued[1]++; end
         end
         if (!row_v || acc[2]) begin
            row_v = 1'b0;
            if (issued[2] < n_sets && roll(p_val)) begin row_v = 1'b1; row_i = 2'($urandom); issued[2]++; end
         end
         if (!data_v || acc[3]) begin
            data_v = 1'b0;
            if (issued[3] < n_sets && roll(p_val)) begin data_v = 1'b1; data_i = DW'($urandom); issued[3]++; end
         end
         pr = roll(p_rdy);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_all(input logic v, input logic ts, input logic ibf,
                          input logic [1:0] row, input logic [DW-1:0] d);
      ts_v = v; ibf_v = v; row_v = v; data_v = v;
      ts_i = ts; ibf_i = ibf; row_i = row; data_i = d;
   endtask

   task automatic run_random(input int sets, input int pv_pct, input int pr_pct, input int budget);
      int start;
      start = npkts;
      for (int f = 0; f < 4; f++) issued[f] = 0;
      n_sets = sets; p_val = pv_pct; p_rdy = pr_pct;
      rnd_en = 1'b1;
      for (int c = 0; c < budget && (npkts - start) < sets; c++) cyc();
      chk("random_packet_count", npkts - start, sets);
      rnd_en = 1'b0;
      cyc();
      set_all(1'b0, 1'b0, 1'b0, 2'd0, '0);
      pr = 1'b1;
      repeat (3) cyc();
   endtask

   logic [OW-1:0] e;
   int            s0;

   initial begin
      // Reset state
      #12;
      chk("reset_packet_valid", pv, 1'b0);
      chk("reset_packet_o", pkt, '0);
      chk("reset_readies", {ts_r, ibf_r, row_r, data_r}, 4'hF);
      #1 rst_n = 1'b1;
      cyc();

      // Directed packet
      pr = 1'b1;
      set_all(1'b1, 1'b1, 1'b0, 2'b10, 24'hA5C3F0);
      cyc();
      set_all(1'b0, 1'b0, 1'b0, 2'd0, '0);
      cyc();
      e = '0;
      e[27:0] = 28'hAA5C3F0;
      chk("directed_valid", pv, 1'b1);
      chk("directed_packet", pkt, e);
      cyc();
      chk("directed_one_cycle", pv, 1'b0);

      // Out-of-order fields
      for (int c = 0; c <= 9; c++) begin
         data_v = (c <= 1); data_i = (c == 0) ? 24'h123456 : 24'hFFFFFF;
         row_v = (c == 3); row_i = 2'b10;
         ts_v = (c == 5); ts_i = 1'b1;
         ibf_v = (c == 7); ibf_i = 1'b1;
         #1;
         if (c == 1) chk("ooo_data_blocked", data_r, 1'b0);
         if (c == 8) chk("ooo_not_yet", pv, 1'b0);
         if (c == 9) begin
            e = '0;
            e[27:0] = {4'hE, 24'h123456};
            chk("ooo_valid", pv, 1'b1);
            chk("ooo_packet", pkt, e);
         end
         cyc();
      end
      set_all(1'b0, 1'b0, 1'b0, 2'd0, '0);
      repeat (2) cyc();

      // Backpressure
      pr = 1'b0;
      set_all(1'b1, 1'b0, 1'b1, 2'd1, 24'h0F0F0F);
      cyc();
      set_all(1'b0, 1'b0, 1'b0, 2'd0, '0);
      cyc();
      set_all(1'b1, 1'b1, 1'b1, 2'd3, 24'h987654);
      cyc();
      set_all(1'b0, 1'b0, 1'b0, 2'd0, '0);
      #1;
      chk("bp_readies_low", {ts_r, ibf_r, row_r, data_r}, 4'h0);
      repeat (8) cyc();
      chk("bp_packet_held", pkt, mkpkt(1'b0, 1'b1, 2'd1, 24'h0F0F0F));
      pr = 1'b1;
      cyc();
      chk("bp_second_loaded", pkt, mkpkt(1'b1, 1'b1, 2'd3, 24'h987654));
      chk("bp_second_valid", pv, 1'b1);
      cyc();
      chk("bp_drained", pv, 1'b0);

      // Reset with two fields captured
      ts_v = 1'b1; ts_i = 1'b1; data_v = 1'b1; data_i = 24'hCAFE01;
      cyc();
      set_all(1'b0, 1'b0, 1'b0, 2'd0, '0);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_partial_readies", {ts_r, ibf_r, row_r, data_r}, 4'hF);
      cyc();
      rst_n = 1'b1;
      ibf_v = 1'b1; ibf_i = 1'b0; row_v = 1'b1; row_i = 2'd2;
      cyc();
      set_all(1'b0, 1'b0, 1'b0, 2'd0, '0);
      repeat (4) cyc();
      chk("rst_partial_discarded", pv, 1'b0);
      ts_v = 1'b0 | 1'b1; ts_i = 1'b0; data_v = 1'b1; data_i = 24'h00BEEF;
      cyc();
      set_all(1'b0, 1'b0, 1'b0, 2'd0, '0);
      cyc();
      chk("rst_partial_new_packet", pkt, mkpkt(1'b0, 1'b0, 2'd2, 24'h00BEEF));

      // Reset while the output holds a packet
      cyc();
      pr = 1'b0;
      set_all(1'b1, 1'b1, 1'b0, 2'd1, 24'h55AA33);
      cyc();
      set_all(1'b0, 1'b0, 1'b0, 2'd0, '0);
      repeat (2) cyc();
      chk("rst_full_before", pv, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_full_valid_drop", pv, 1'b0);
      chk("rst_full_packet_clear", pkt, '0);
      cyc();
      rst_n = 1'b1;
      pr = 1'b1;
      repeat (5) cyc();
      chk("rst_full_no_packet", pv, 1'b0);

      // Streaming: 100 sets, valids always high, ready always high
      s0 = npkts;
      for (int f = 0; f < 4; f++) issued[f] = 0;
      n_sets = 100; p_val = 100; p_rdy = 100;
      rnd_en = 1'b1;
      repeat (102) cyc();
      @(negedge clk);
      #2;
      chk("stream_throughput", npkts - s0, 100);
      rnd_en = 1'b0;
      @(posedge clk);
      #1;
      set_all(1'b0, 1'b0, 1'b0, 2'd0, '0);
      repeat (3) cyc();

      // Random valids and stalls
      run_random(1000, 70, 60, 20000);
      run_random(300, 40, 90, 6000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
